// File: rtl/swc_rd_sched_np.sv
// Egress read scheduler: grants one port queue per cell, reads the cell from data SRAM,
// forwards the beats to that port's egress FIFO and retires the pointer on its last reference.
module swc_rd_sched_np #(
  parameter int NPORTS   = 4,
  parameter int PTR_W    = 10,
  parameter int BEATS    = 4,
  parameter int DW       = 128,
  parameter int MC_W     = 4,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0,
  localparam int BW      = $clog2(BEATS),
  localparam int AW      = PTR_W + BW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NPORTS-1:0]    qc_ptr_rdy,
  input  logic [NPORTS*16-1:0] qc_ptr_dout,
  output logic [NPORTS-1:0]    qc_ptr_ack,
  input  logic [NPORTS-1:0]    o_cell_bp,
  output logic                 sram_rd_en,
  output logic [AW-1:0]        sram_rd_addr,
  input  logic [DW-1:0]        sram_rd_data,
  output logic [PTR_W-1:0]     mc_rd_addr,
  input  logic [MC_W-1:0]      mc_rd_data,
  output logic                 mc_wr_en,
  output logic [PTR_W-1:0]     mc_wr_addr,
  output logic [MC_W-1:0]      mc_wr_data,
  output logic                 fq_wr,
  output logic [PTR_W-1:0]     fq_din,
  output logic [NPORTS-1:0]    o_cell_fifo_wr,
  output logic [DW-1:0]        o_cell_fifo_din,
  output logic                 o_cell_first,
  output logic                 o_cell_last,
  output logic                 err_refcnt,
  output logic                 busy
);

  localparam int PW = $clog2(NPORTS);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    READ
  } state_t;

  typedef struct packed {
    logic              v;
    logic              first;
    logic              last;
    logic [NPORTS-1:0] sel;
  } tag_t;

  state_t            state, state_nx;
  logic [PW-1:0]     rr, rr_nx, gidx;
  logic [PTR_W-1:0]  ptr, ptr_nx;
  logic              first, first_nx;
  logic              last, last_nx;
  logic [NPORTS-1:0] sel, sel_nx;
  logic [NPORTS-1:0] req, mask, gnt;
  logic [BW-1:0]     beat, beat_nx;
  logic [15:0]       word;
  logic              unused_word;
  tag_t              tag_in;
  tag_t              pipe [RD_LAT];
  logic              pend;

  function automatic logic [PW-1:0] lsb_idx(input logic [NPORTS-1:0] v);
    lsb_idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--)
      if (v[i]) lsb_idx = PW'(i);
  endfunction

  assign req = qc_ptr_rdy & ~o_cell_bp;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NPORTS; i++)
      mask[i] = (PW'(i) >= rr);
  end

  // Round-robin searches upward from rr and wraps to the lowest request.
  always_comb begin
    gidx = '0;
    if (ARB_MODE != 0)
      gidx = lsb_idx(req);
    else if (|(req & mask))
      gidx = lsb_idx(req & mask);
    else
      gidx = lsb_idx(req);
  end

  assign gnt = NPORTS'(1) << gidx;

  always_comb begin
    word = '0;
    for (int i = 0; i < NPORTS; i++)
      if (gidx == PW'(i)) word = qc_ptr_dout[i*16 +: 16];
  end

  assign unused_word = ^word;

  always_comb begin
    state_nx   = state;
    rr_nx      = rr;
    ptr_nx     = ptr;
    first_nx   = first;
    last_nx    = last;
    sel_nx     = sel;
    beat_nx    = beat;
    qc_ptr_ack = '0;
    sram_rd_en = 1'b0;
    mc_wr_en   = 1'b0;
    mc_wr_data = '0;
    fq_wr      = 1'b0;
    err_refcnt = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) state_nx = ARB;
      end
      ARB: begin
        if (!(|req)) begin
          state_nx = IDLE;
        end else begin
          qc_ptr_ack = gnt;
          ptr_nx     = word[PTR_W-1:0];
          first_nx   = word[14];
          last_nx    = word[15];
          sel_nx     = gnt;
          beat_nx    = '0;
          state_nx   = READ;
          if (ARB_MODE == 0)
            rr_nx = (gidx == PW'(NPORTS - 1)) ? '0 : gidx + PW'(1);
        end
      end
      READ: begin
        sram_rd_en = 1'b1;
        beat_nx    = beat + BW'(1);
        // Refcount read issued on beat 0 returns on beat 1.
        if (beat == BW'(1)) begin
          mc_wr_en = 1'b1;
          if (mc_rd_data > MC_W'(1))
            mc_wr_data = mc_rd_data - MC_W'(1);
          else if (mc_rd_data == MC_W'(1))
            fq_wr = 1'b1;
          else
            err_refcnt = 1'b1;
        end
        if (beat == BW'(BEATS - 1))
          state_nx = (|req) ? ARB : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rr    <= '0;
      ptr   <= '0;
      first <= 1'b0;
      last  <= 1'b0;
      sel   <= '0;
      beat  <= '0;
    end else begin
      state <= state_nx;
      rr    <= rr_nx;
      ptr   <= ptr_nx;
      first <= first_nx;
      last  <= last_nx;
      sel   <= sel_nx;
      beat  <= beat_nx;
    end
  end

  assign sram_rd_addr = {ptr, beat};
  assign mc_rd_addr   = ptr;
  assign mc_wr_addr   = ptr;
  assign fq_din       = ptr;

  assign tag_in = {sram_rd_en, first, last, sel};

  // Tags travel with each read so back-to-back cells keep their own flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      o_cell_fifo_wr  <= '0;
      o_cell_fifo_din <= '0;
      o_cell_first    <= 1'b0;
      o_cell_last     <= 1'b0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      o_cell_fifo_wr  <= pipe[RD_LAT-1].v ? pipe[RD_LAT-1].sel : '0;
      o_cell_fifo_din <= pipe[RD_LAT-1].v ? sram_rd_data : '0;
      o_cell_first    <= pipe[RD_LAT-1].v & pipe[RD_LAT-1].first;
      o_cell_last     <= pipe[RD_LAT-1].v & pipe[RD_LAT-1].last;
    end
  end

  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pend = pend | pipe[i].v;
  end

  assign busy = (state != IDLE) | pend | (|o_cell_fifo_wr);

endmodule

// File: tb/tb_swc_rd_sched_np.sv
// Bench for swc_rd_sched_np: queue/SRAM/refcount models, grant and beat scoreboard,
// refcount vector table and hand-built timing, backpressure and reset sequences.
module tb_swc_rd_sched_np;

  localparam int NP = 4;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NP-1:0]   qc_ptr_rdy = '0;
  logic [NP*16-1:0] qc_ptr_dout = '0;
  logic [NP-1:0]   o_cell_bp = '0;
  logic [DW-1:0]   sram_rd_data = '0;
  logic [3:0]      mc_rd_data = '0;

  logic [NP-1:0]   qc_ptr_ack;
  logic            sram_rd_en;
  logic [11:0]     sram_rd_addr;
  logic [9:0]      mc_rd_addr;
  logic            mc_wr_en;
  logic [9:0]      mc_wr_addr;
  logic [3:0]      mc_wr_data;
  logic            fq_wr;
  logic [9:0]      fq_din;
  logic [NP-1:0]   o_cell_fifo_wr;
  logic [DW-1:0]   o_cell_fifo_din;
  logic            o_cell_first;
  logic            o_cell_last;
  logic            err_refcnt;
  logic            busy;

  logic [NP-1:0]   sp_ack;
  logic            sp_rd_en;
  logic [11:0]     sp_rd_addr;
  logic [9:0]      sp_mc_rd_addr;
  logic            sp_mc_wr_en;
  logic [9:0]      sp_mc_wr_addr;
  logic [3:0]      sp_mc_wr_data;
  logic            sp_fq_wr;
  logic [9:0]      sp_fq_din;
  logic [NP-1:0]   sp_fifo_wr;
  logic [DW-1:0]   sp_fifo_din;
  logic            sp_first;
  logic            sp_last;
  logic            sp_err;
  logic            sp_busy;

  swc_rd_sched_np u_rr (
    .clk(clk), .rstn(rstn),
    .qc_ptr_rdy(qc_ptr_rdy), .qc_ptr_dout(qc_ptr_dout), .qc_ptr_ack(qc_ptr_ack),
    .o_cell_bp(o_cell_bp),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .mc_rd_addr(mc_rd_addr), .mc_rd_data(mc_rd_data),
    .mc_wr_en(mc_wr_en), .mc_wr_addr(mc_wr_addr), .mc_wr_data(mc_wr_data),
    .fq_wr(fq_wr), .fq_din(fq_din),
    .o_cell_fifo_wr(o_cell_fifo_wr), .o_cell_fifo_din(o_cell_fifo_din),
    .o_cell_first(o_cell_first), .o_cell_last(o_cell_last),
    .err_refcnt(err_refcnt), .busy(busy)
  );

  swc_rd_sched_np #(.ARB_MODE(1)) u_sp (
    .clk(clk), .rstn(rstn),
    .qc_ptr_rdy(qc_ptr_rdy), .qc_ptr_dout(qc_ptr_dout), .qc_ptr_ack(sp_ack),
    .o_cell_bp(o_cell_bp),
    .sram_rd_en(sp_rd_en), .sram_rd_addr(sp_rd_addr), .sram_rd_data('0),
    .mc_rd_addr(sp_mc_rd_addr), .mc_rd_data(4'd1),
    .mc_wr_en(sp_mc_wr_en), .mc_wr_addr(sp_mc_wr_addr), .mc_wr_data(sp_mc_wr_data),
    .fq_wr(sp_fq_wr), .fq_din(sp_fq_din),
    .o_cell_fifo_wr(sp_fifo_wr), .o_cell_fifo_din(sp_fifo_din),
    .o_cell_first(sp_first), .o_cell_last(sp_last),
    .err_refcnt(sp_err), .busy(sp_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] cell_data(logic [11:0] a);
    return {4{20'hA5C3E, a}};
  endfunction

  function automatic int rr_pick(logic [NP-1:0] r, int p);
    for (int i = 0; i < NP; i++)
      if (r[(p + i) % NP]) return (p + i) % NP;
    return -1;
  endfunction

  // Queue controller, data SRAM and refcount RAM models
  logic [15:0]   pq [NP][$];
  logic [NP-1:0] hold = '0;
  logic [NP-1:0] ack_s = '0;
  logic [3:0]    rc_mem [1024];

  task automatic drive_ports();
    for (int i = 0; i < NP; i++) begin
      qc_ptr_rdy[i] = (pq[i].size() != 0) && !hold[i];
      qc_ptr_dout[i*16 +: 16] = (pq[i].size() != 0) ? pq[i][0] : 16'h0;
    end
  endtask

  task automatic push(int p, logic [9:0] ptr, logic f, logic l, logic pre, logic [3:0] rc);
    if (pre) rc_mem[ptr] = rc;
    pq[p].push_back({l, f, 4'h0, ptr});
    drive_ports();
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NP; i++) n += pq[i].size();
    return n;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NP; i++)
      if (ack_s[i] && pq[i].size() != 0) void'(pq[i].pop_front());
    ack_s = '0;
    drive_ports();
  end

  always @(posedge clk) begin
    sram_rd_data <= sram_rd_en ? cell_data(sram_rd_addr) : '0;
    mc_rd_data   <= rc_mem[mc_rd_addr];
    if (mc_wr_en) rc_mem[mc_wr_addr] = mc_wr_data;
  end

  // Grant model and beat scoreboard
  logic [133:0]  expq [$];
  int            rr_m = 0;
  int            cyc = 0;
  int            n_ack = 0;
  int            n_sp = 0;
  int            n_fq = 0;
  int            n_mcw = 0;
  int            n_beats = 0;
  int            prev_ack = -1;
  int            sp_err_cnt = 0;
  bit            spacing_on = 0;
  logic [NP-1:0] req_m;
  logic [15:0]   word_m;
  int            g;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn) begin
      req_m = qc_ptr_rdy & ~o_cell_bp;
      ack_s = qc_ptr_ack;
      if (qc_ptr_ack != '0) begin
        g = rr_pick(req_m, rr_m);
        chk("grant", qc_ptr_ack, (g < 0) ? 4'h0 : 4'(1 << g));
        if (g >= 0) begin
          rr_m = (g + 1) % NP;
          word_m = qc_ptr_dout[g*16 +: 16];
          for (int b = 0; b < 4; b++)
            expq.push_back({4'(1 << g), word_m[14], word_m[15],
                            cell_data({word_m[9:0], 2'(b)})});
        end
        n_ack++;
        if (spacing_on) begin
          if (prev_ack >= 0 && cyc - prev_ack != 5) sp_err_cnt++;
          prev_ack = cyc;
        end
      end
      if (sp_ack != '0) begin
        g = rr_pick(req_m, 0);
        chk("sp_grant", sp_ack, (g < 0) ? 4'h0 : 4'(1 << g));
        n_sp++;
      end
      if (o_cell_fifo_wr != '0) begin
        n_beats++;
        if (expq.size() == 0)
          chk("beat_extra", o_cell_fifo_wr, 0);
        else
          chk("beat", {o_cell_fifo_wr, o_cell_first, o_cell_last, o_cell_fifo_din},
              expq.pop_front());
      end
      if (fq_wr) n_fq++;
      if (mc_wr_en) n_mcw++;
    end
  end

  task automatic wait_idle(int lim);
    bit ok = 0;
    for (int c = 0; c < lim && !ok; c++) begin
      @(negedge clk);
      if (!busy && pending() == 0) ok = 1;
    end
    if (!ok) chk("idle_timeout", ok, 1);
  endtask

  typedef struct {
    int         port;
    logic [9:0] ptr;
    logic       pre;
    logic [3:0] rc;
    logic       f;
    logic       l;
    logic [3:0] wd;
    logic       fq;
    logic       err;
  } vec_t;

  vec_t tv [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  t_ack, t_rd, t_wr, n_rd, n_wr, a_err, base, base2, bbase;
    logic [3:0] first_wr;
    bit  got;

    tv[0] = '{2, 10'h005, 1, 4'd1,  1, 1, 4'd0,  1, 0};
    tv[1] = '{0, 10'h009, 1, 4'd2,  1, 0, 4'd1,  0, 0};
    tv[2] = '{3, 10'h009, 0, 4'd0,  1, 0, 4'd0,  1, 0};
    tv[3] = '{1, 10'h3FF, 1, 4'd0,  0, 1, 4'd0,  0, 1};
    tv[4] = '{0, 10'h100, 1, 4'd15, 0, 0, 4'd14, 0, 0};
    tv[5] = '{3, 10'h2AA, 1, 4'd3,  0, 1, 4'd2,  0, 0};

    for (int i = 0; i < 1024; i++) rc_mem[i] = '0;
    drive_ports();

    repeat (3) @(negedge clk);
    chk("rst_ctl", {qc_ptr_ack, sram_rd_en, mc_wr_en, fq_wr, o_cell_fifo_wr,
                    o_cell_first, o_cell_last, err_refcnt, busy}, 0);
    chk("rst_addr", {sram_rd_addr, mc_rd_addr, mc_wr_addr, mc_wr_data, fq_din}, 0);
    chk("rst_din", o_cell_fifo_din, 0);
    #1 rstn = 1'b1;

    // Single cell on port 2: ack, read addresses and delivery timing
    @(negedge clk); #1;
    push(2, 10'h005, 1, 1, 1, 4'd1);
    t_ack = -100; t_rd = -100; t_wr = -100;
    n_rd = 0; n_wr = 0; a_err = 0; first_wr = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (qc_ptr_ack != '0 && t_ack < 0) t_ack = c;
      if (sram_rd_en) begin
        if (t_rd < 0) t_rd = c;
        if (sram_rd_addr != 12'(12'h014 + n_rd)) a_err++;
        n_rd++;
      end
      if (o_cell_fifo_wr != '0) begin
        if (t_wr < 0) begin
          t_wr = c;
          first_wr = o_cell_fifo_wr;
        end
        n_wr++;
      end
    end
    chk("t_rd_after_ack", t_rd - t_ack, 1);
    chk("t_wr_after_rd", t_wr - t_rd, 2);
    chk("n_rd", n_rd, 4);
    chk("n_wr", n_wr, 4);
    chk("rd_addr_err", a_err, 0);
    chk("wr_sel", first_wr, 4'b0100);
    chk("rc_after_single", rc_mem[10'h005], 0);

    // Refcount table: unicast, multicast pair, error, large counts
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      push(tv[k].port, tv[k].ptr, tv[k].f, tv[k].l, tv[k].pre, tv[k].rc);
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (mc_wr_en) begin
          got = 1;
          chk("mc_wr_data", mc_wr_data, tv[k].wd);
          chk("mc_wr_addr", mc_wr_addr, tv[k].ptr);
          chk("fq", {fq_wr, fq_wr ? fq_din : 10'h0},
              {tv[k].fq, tv[k].fq ? tv[k].ptr : 10'h0});
          chk("err_refcnt", err_refcnt, tv[k].err);
        end
      end
      if (!got) chk("mc_timeout", got, 1);
      wait_idle(40);
    end

    // Ready drops between IDLE and ARB: no grant
    @(negedge clk); #1;
    base = n_ack;
    push(2, 10'h030, 0, 0, 1, 4'd1);
    @(posedge clk); #1;
    hold[2] = 1'b1;
    drive_ports();
    repeat (5) @(negedge clk);
    chk("drop_no_ack", n_ack - base, 0);
    #1 hold[2] = 1'b0;
    drive_ports();
    wait_idle(40);
    chk("drop_then_ack", n_ack - base, 1);

    // Round-robin with all four ports backlogged
    @(negedge clk); #1;
    base = n_ack; base2 = n_fq; bbase = n_beats;
    prev_ack = -1; sp_err_cnt = 0; spacing_on = 1;
    for (int n = 0; n < 8; n++)
      for (int p = 0; p < NP; p++)
        push(p, 10'(10'h040 + p * 8 + n), n == 0, n == 7, 1, 4'd1);
    wait_idle(400);
    spacing_on = 0;
    chk("rr_acks", n_ack - base, 32);
    chk("rr_spacing_err", sp_err_cnt, 0);
    chk("rr_fq", n_fq - base2, 32);
    chk("rr_beats", n_beats - bbase, 128);

    // Ports 1 and 3 backlogged: strict instance must keep choosing port 1
    @(negedge clk); #1;
    base = n_sp;
    for (int n = 0; n < 3; n++) push(1, 10'(10'h080 + n), 0, 0, 1, 4'd1);
    for (int n = 0; n < 2; n++) push(3, 10'(10'h090 + n), 0, 0, 1, 4'd1);
    wait_idle(100);
    chk("sp_active", n_sp - base > 0, 1);

    // Backpressure: held off, released, raised mid-cell
    @(negedge clk); #1;
    base = n_ack;
    o_cell_bp = 4'b0001;
    push(0, 10'h0A0, 1, 0, 1, 4'd1);
    push(0, 10'h0A1, 0, 1, 1, 4'd1);
    repeat (10) @(negedge clk);
    chk("bp_no_ack", n_ack - base, 0);
    #1 o_cell_bp = 4'b0000;
    got = 0;
    for (int c = 0; c < 2 && !got; c++) begin
      @(negedge clk);
      if (n_ack > base) got = 1;
    end
    chk("bp_grant_2cyc", got, 1);
    @(posedge clk); #1;
    o_cell_bp = 4'b0001;
    bbase = n_beats - (n_beats % 1);
    repeat (12) @(negedge clk);
    chk("bp_one_cell", n_ack - base, 1);
    chk("bp_cell_done", expq.size(), 0);
    #1 o_cell_bp = 4'b0000;
    wait_idle(40);
    chk("bp_second", n_ack - base, 2);

    // Reset during beat 2 of a cell
    @(negedge clk); #1;
    push(1, 10'h020, 1, 1, 1, 4'd1);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (sram_rd_en && sram_rd_addr[1:0] == 2'd2) got = 1;
    end
    chk("mid_reach_beat2", got, 1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_ctl", {qc_ptr_ack, sram_rd_en, mc_wr_en, fq_wr, o_cell_fifo_wr,
                        o_cell_first, o_cell_last, err_refcnt, busy}, 0);
    chk("mid_rst_addr", {sram_rd_addr, mc_rd_addr, fq_din, o_cell_fifo_din[31:0]}, 0);
    expq.delete();
    rr_m = 0;
    ack_s = '0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    base = n_fq; base2 = n_mcw; bbase = n_beats;
    repeat (10) @(negedge clk);
    chk("mid_no_fq", n_fq - base, 0);
    chk("mid_no_mcw", n_mcw - base2, 0);
    chk("mid_no_beats", n_beats - bbase, 0);
    chk("mid_idle", busy, 0);

    chk("sb_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
